// File: rtl/alu_ctl_issue.sv
// alu_ctl_issue: decodes RV32I instructions into registered one-hot ALU/BRU controls with valid/ready handshake.
// Build option ALU_CTL_SKID_EN: two-entry skid buffer with a registered in_ready; default is a single output register.
module alu_ctl_issue #(
   parameter int PAYLOAD_W = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [9:0]           out_ALUctl,
   output logic [6:0]           out_BRUctl,
   output logic                 out_illegal,
   output logic [PAYLOAD_W-1:0] out_payload
);
   localparam int EW = PAYLOAD_W + 18;
   localparam int A_SLTU = 0, A_SLT = 1, A_ADD = 2, A_SUB = 3, A_XOR = 4;
   localparam int A_OR = 5, A_AND = 6, A_SLL = 7, A_SRL = 8, A_SRA = 9;
   localparam int B_JUMP = 6;

   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic [6:0]    funct7;
   logic [9:0]    dec_alu;
   logic [6:0]    dec_bru;
   logic          dec_ill;
   logic          unused_instr;
   logic [EW-1:0] in_ent;
   logic [EW-1:0] main_q, main_d;
   logic          m_valid_q, m_valid_d;
   logic          accept;

   assign opcode       = in_instr[6:0];
   assign funct3       = in_instr[14:12];
   assign funct7       = in_instr[31:25];
   assign unused_instr = ^{in_instr[24:15], in_instr[11:7]};

   function automatic logic [9:0] base_alu(input logic [2:0] f3);
      logic [9:0] a;
      a = '0;
      case (f3)
         3'b000:  a[A_ADD]  = 1'b1;
         3'b001:  a[A_SLL]  = 1'b1;
         3'b010:  a[A_SLT]  = 1'b1;
         3'b011:  a[A_SLTU] = 1'b1;
         3'b100:  a[A_XOR]  = 1'b1;
         3'b101:  a[A_SRL]  = 1'b1;
         3'b110:  a[A_OR]   = 1'b1;
         default: a[A_AND]  = 1'b1;
      endcase
      return a;
   endfunction

   always_comb begin
      dec_alu = '0;
      dec_bru = '0;
      dec_ill = 1'b0;
      case (opcode)
         7'b0110011: begin
            if (funct7 == 7'b0000000)                          dec_alu = base_alu(funct3);
            else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec_alu[A_SUB] = 1'b1;
            else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec_alu[A_SRA] = 1'b1;
            else                                               dec_ill = 1'b1;
         end
         7'b0010011: begin
            if (funct3 == 3'b001 && funct7 != 7'b0000000) dec_ill = 1'b1;
            else if (funct3 == 3'b101) begin
               if (funct7 == 7'b0000000)      dec_alu[A_SRL] = 1'b1;
               else if (funct7 == 7'b0100000) dec_alu[A_SRA] = 1'b1;
               else                           dec_ill = 1'b1;
            end
            else dec_alu = base_alu(funct3);
         end
         7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111: dec_alu[A_ADD] = 1'b1;
         7'b1101111: begin
            dec_alu[A_ADD]  = 1'b1;
            dec_bru[B_JUMP] = 1'b1;
         end
         7'b1100111: begin
            if (funct3 == 3'b000) begin
               dec_alu[A_ADD]  = 1'b1;
               dec_bru[B_JUMP] = 1'b1;
            end
            else dec_ill = 1'b1;
         end
         7'b1100011: begin
            case (funct3)
               3'b000:  dec_bru[0] = 1'b1;
               3'b001:  dec_bru[1] = 1'b1;
               3'b100:  dec_bru[2] = 1'b1;
               3'b101:  dec_bru[3] = 1'b1;
               3'b110:  dec_bru[4] = 1'b1;
               3'b111:  dec_bru[5] = 1'b1;
               default: dec_ill    = 1'b1;
            endcase
         end
         7'b0001111, 7'b1110011: ;
         // every legal opcode ends in 2'b11, so compressed encodings fall here too
         default: dec_ill = 1'b1;
      endcase
   end

   assign in_ent = {dec_ill, dec_bru, dec_alu, in_payload};
   assign {out_illegal, out_BRUctl, out_ALUctl, out_payload} = main_q;
   assign out_valid = m_valid_q;
   assign accept    = in_valid & in_ready;

`ifdef ALU_CTL_SKID_EN
   logic          s_valid_q, s_valid_d;
   logic          rdy_q, rdy_d;
   logic [EW-1:0] skid_q, skid_d;

   assign in_ready = rdy_q;

   always_comb begin
      m_valid_d = m_valid_q;
      main_d    = main_q;
      s_valid_d = s_valid_q;
      skid_d    = skid_q;
      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end
      else begin
         if (m_valid_q && out_ready) begin
            if (s_valid_q) begin
               main_d    = skid_q;
               s_valid_d = 1'b0;
            end
            else m_valid_d = 1'b0;
         end
         // accept implies the skid slot was empty, so no entry is overwritten
         if (accept) begin
            if (!m_valid_d) begin
               m_valid_d = 1'b1;
               main_d    = in_ent;
            end
            else begin
               s_valid_d = 1'b1;
               skid_d    = in_ent;
            end
         end
      end
      rdy_d = ~s_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         main_q    <= '0;
         s_valid_q <= 1'b0;
         skid_q    <= '0;
         rdy_q     <= 1'b0;
      end
      else begin
         m_valid_q <= m_valid_d;
         main_q    <= main_d;
         s_valid_q <= s_valid_d;
         skid_q    <= skid_d;
         rdy_q     <= rdy_d;
      end
   end
`else
   logic rdy_en_q;

   // rdy_en_q keeps in_ready low until the first clock after reset release
   assign in_ready = rdy_en_q & (~m_valid_q | out_ready);

   always_comb begin
      m_valid_d = m_valid_q;
      main_d    = main_q;
      if (flush) m_valid_d = 1'b0;
      else if (accept) begin
         m_valid_d = 1'b1;
         main_d    = in_ent;
      end
      else if (out_ready) m_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         main_q    <= '0;
         rdy_en_q  <= 1'b0;
      end
      else begin
         m_valid_q <= m_valid_d;
         main_q    <= main_d;
         rdy_en_q  <= 1'b1;
      end
   end
`endif

endmodule
